// File: rtl/cpu_pkg.sv
// cpu_pkg: shared opcodes, fetch FSM state encoding and instruction length decode.
package cpu_pkg;

    localparam int ADDR_W = 13;

    localparam logic [2:0] OP_LDI   = 3'b000;
    localparam logic [2:0] OP_ADD   = 3'b001;
    localparam logic [2:0] OP_STORE = 3'b010;
    localparam logic [2:0] OP_JMP   = 3'b011;

    typedef enum logic [2:0] {
        IDLE,
        B0_REQ,
        B0_CAP,
        B1_REQ,
        B1_CAP,
        HOLD
    } fetch_state_t;

    // Memory-reference opcodes (OP_LDI..OP_JMP) carry a second address byte.
    function automatic logic is_two_byte(input logic [7:0] byte0);
        return byte0[7:5] <= OP_JMP;
    endfunction

endpackage

// File: rtl/instr_fetch.sv
// instr_fetch: byte-wide fetch of 1/2-byte instructions with valid/ready output and jump flush.
// Optional FETCH_WRAP_CHECK_EN adds a sticky pc_wrap flag on PC rollover.
module instr_fetch #(
    parameter int ADDR_W = 13,
    parameter logic [ADDR_W-1:0] RESET_PC = 13'd0
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              fetch_en,
    output logic              memRead,
    output logic [ADDR_W-1:0] addressMem,
    input  logic [7:0]        memOut,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [2:0]        instr_op,
    output logic [7:0]        instr_byte0,
    output logic [ADDR_W-1:0] instr_addr,
    output logic              instr_two_byte,
    output logic [ADDR_W-1:0] instr_pc,
    input  logic              jump_en,
    input  logic [ADDR_W-1:0] jump_target
`ifdef FETCH_WRAP_CHECK_EN
    ,
    output logic              pc_wrap
`endif
);
    import cpu_pkg::*;

    fetch_state_t      state;
    logic [ADDR_W-1:0] pc;

    // Jump is checked ahead of the state case so it overrides every transition.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            pc             <= RESET_PC;
            memRead        <= 1'b0;
            addressMem     <= '0;
            instr_valid    <= 1'b0;
            instr_op       <= '0;
            instr_byte0    <= '0;
            instr_addr     <= '0;
            instr_two_byte <= 1'b0;
            instr_pc       <= '0;
        end else begin
            memRead <= 1'b0;
            if (jump_en) begin
                state       <= B0_REQ;
                pc          <= jump_target;
                memRead     <= 1'b1;
                addressMem  <= jump_target;
                instr_valid <= 1'b0;
            end else begin
                case (state)
                    IDLE: if (fetch_en) begin
                        state      <= B0_REQ;
                        memRead    <= 1'b1;
                        addressMem <= pc;
                    end
                    B0_REQ: state <= B0_CAP;
                    B0_CAP: begin
                        pc             <= pc + 1'b1;
                        instr_pc       <= pc;
                        instr_byte0    <= memOut;
                        instr_op       <= memOut[7:5];
                        instr_two_byte <= is_two_byte(memOut);
                        instr_addr     <= is_two_byte(memOut) ? {memOut[4:0], 8'h00} : '0;
                        if (is_two_byte(memOut)) begin
                            state      <= B1_REQ;
                            memRead    <= 1'b1;
                            addressMem <= pc + 1'b1;
                        end else begin
                            state       <= HOLD;
                            instr_valid <= 1'b1;
                        end
                    end
                    B1_REQ: state <= B1_CAP;
                    B1_CAP: begin
                        pc              <= pc + 1'b1;
                        instr_addr[7:0] <= memOut;
                        state           <= HOLD;
                        instr_valid     <= 1'b1;
                    end
                    HOLD: if (instr_ready) begin
                        instr_valid <= 1'b0;
                        if (fetch_en) begin
                            state      <= B0_REQ;
                            memRead    <= 1'b1;
                            addressMem <= pc;
                        end else begin
                            state <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

`ifdef FETCH_WRAP_CHECK_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            pc_wrap <= 1'b0;
        else if (!jump_en && (state == B0_CAP || state == B1_CAP) && pc == '1)
            pc_wrap <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed timing/flush/reset scenarios plus randomized run against an instruction-stream model.
module tb_instr_fetch;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        fetch_en = 1'b0;
    logic        instr_ready = 1'b0;
    logic        jump_en = 1'b0;
    logic [12:0] jump_target = '0;
    logic        memRead;
    logic [12:0] addressMem;
    logic [7:0]  memOut = '0;
    logic        instr_valid;
    logic [2:0]  instr_op;
    logic [7:0]  instr_byte0;
    logic [12:0] instr_addr;
    logic        instr_two_byte;
    logic [12:0] instr_pc;
`ifdef FETCH_WRAP_CHECK_EN
    logic        pc_wrap;
`endif

    instr_fetch dut (
        .clock(clock),
        .reset_n(reset_n),
        .fetch_en(fetch_en),
        .memRead(memRead),
        .addressMem(addressMem),
        .memOut(memOut),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .instr_op(instr_op),
        .instr_byte0(instr_byte0),
        .instr_addr(instr_addr),
        .instr_two_byte(instr_two_byte),
        .instr_pc(instr_pc),
        .jump_en(jump_en),
        .jump_target(jump_target)
`ifdef FETCH_WRAP_CHECK_EN
        ,
        .pc_wrap(pc_wrap)
`endif
    );

    logic [7:0] mem [0:8191];

    always #5 clock = ~clock;

    always @(posedge clock) if (memRead) memOut <= mem[addressMem];

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clock);
    endtask

    function automatic logic [12:0] ilen(input logic [12:0] p);
        logic [7:0] b;
        b = mem[p];
        return (b[7:5] < 3'd4) ? 13'd2 : 13'd1;
    endfunction

    task automatic check_instr(input string tag, input logic [12:0] p);
        logic [7:0]  b0;
        logic [12:0] p1;
        logic        two;
        logic [12:0] a;
        b0  = mem[p];
        p1  = p + 13'd1;
        two = b0[7:5] < 3'd4;
        a   = two ? 13'(b0[4:0]) * 13'd256 + 13'(mem[p1]) : 13'd0;
        check({tag, "_op"}, 32'(instr_op), 32'(b0[7:5]));
        check({tag, "_byte0"}, 32'(instr_byte0), 32'(b0));
        check({tag, "_two"}, 32'(instr_two_byte), 32'(two));
        check({tag, "_addr"}, 32'(instr_addr), 32'(a));
        check({tag, "_pc"}, 32'(instr_pc), 32'(p));
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_mr"}, 32'(memRead), 0);
        check({tag, "_am"}, 32'(addressMem), 0);
        check({tag, "_v"}, 32'(instr_valid), 0);
        check({tag, "_op"}, 32'(instr_op), 0);
        check({tag, "_b0"}, 32'(instr_byte0), 0);
        check({tag, "_ia"}, 32'(instr_addr), 0);
        check({tag, "_two"}, 32'(instr_two_byte), 0);
        check({tag, "_pc"}, 32'(instr_pc), 0);
    endtask

    task automatic wait_mr(input string tag);
        int n;
        n = 0;
        while (!memRead && n < 20) begin tick(); n++; end
        if (!memRead) check({tag, "_mr_timeout"}, 0, 1);
    endtask

    task automatic wait_valid(input string tag, output int n);
        n = 0;
        while (!instr_valid && n < 20) begin tick(); n++; end
        if (!instr_valid) check({tag, "_v_timeout"}, 0, 1);
    endtask

    initial begin
        int n;
        logic [12:0] pc_m;
        logic prev_jump;
        int idle;
        for (int i = 0; i < 8192; i++) mem[i] = 8'hE0;
        mem[0]  = 8'hF0;
        mem[9]  = 8'h43;
        mem[10] = 8'hE9;
        mem[11] = 8'h05;
        mem[12] = 8'h77;
        mem[43] = 8'h8A;
        mem[44] = 8'h21;
        mem[45] = 8'h34;
        tick();
        check_zero("rst");
        reset_n = 1'b1;
        fetch_en = 1'b1;
        instr_ready = 1'b1;
        wait_mr("t1");
        check("t1_addr", 32'(addressMem), 0);
        wait_valid("t1", n);
        check("t1_lat", n, 2);
        check_instr("t1", 13'd0);
        jump_en = 1'b1;
        jump_target = 13'd9;
        tick();
        jump_en = 1'b0;
        instr_ready = 1'b0;
        check("t2_flush_v", 32'(instr_valid), 0);
        check("t2_mr", 32'(memRead), 1);
        check("t2_am", 32'(addressMem), 9);
        wait_valid("t2", n);
        check("t2_lat", n, 4);
        check("t2_addr1001", 32'(instr_addr), 1001);
        check_instr("t2", 13'd9);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t3_v", 32'(instr_valid), 1);
            check("t3_mr", 32'(memRead), 0);
            check("t3_addr", 32'(instr_addr), 1001);
            check("t3_pc", 32'(instr_pc), 9);
        end
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        check("t3_next_mr", 32'(memRead), 1);
        check("t3_next_am", 32'(addressMem), 11);
        tick();
        tick();
        check("t4_b1_mr", 32'(memRead), 1);
        check("t4_b1_am", 32'(addressMem), 12);
        tick();
        jump_en = 1'b1;
        jump_target = 13'd43;
        tick();
        jump_en = 1'b0;
        instr_ready = 1'b1;
        check("t4_flush_v", 32'(instr_valid), 0);
        check("t4_am", 32'(addressMem), 43);
        wait_valid("t4", n);
        check("t4_lat", n, 2);
        check_instr("t4", 13'd43);
        tick();
        check("t5_am", 32'(addressMem), 44);
        tick();
        tick();
        check("t5_b1_am", 32'(addressMem), 45);
        reset_n = 1'b0;
        #1;
        check_zero("t5_async");
        tick();
        reset_n = 1'b1;
        wait_mr("t5");
        check("t5_restart_am", 32'(addressMem), 0);
        wait_valid("t5", n);
        check_instr("t5", 13'd0);
        jump_en = 1'b1;
        jump_target = 13'd8191;
        tick();
        jump_en = 1'b0;
        wait_valid("t6", n);
        check_instr("t6", 13'd8191);
`ifdef FETCH_WRAP_CHECK_EN
        check("t6_wrap", 32'(pc_wrap), 1);
`endif
        tick();
        check("t6_wrap_am", 32'(addressMem), 0);
        wait_valid("t6b", n);
        check_instr("t6b", 13'd0);
`ifdef FETCH_WRAP_CHECK_EN
        check("t6_wrap_sticky", 32'(pc_wrap), 1);
`endif

        reset_n = 1'b0;
        tick();
        for (int i = 0; i < 8192; i++) mem[i] = 8'($urandom);
        reset_n = 1'b1;
        pc_m = '0;
        prev_jump = 1'b0;
        idle = 0;
        for (int c = 0; c < 3000; c++) begin
            fetch_en    = $urandom_range(0, 9) != 0;
            instr_ready = $urandom_range(0, 9) < 7;
            jump_en     = $urandom_range(0, 29) == 0;
            jump_target = ($urandom_range(0, 3) == 0) ? 13'(8190 + $urandom_range(0, 1)) : 13'($urandom_range(0, 8191));
            if (prev_jump) check("rnd_flush", 32'(instr_valid), 0);
            if (instr_valid) check("rnd_hold_mr", 32'(memRead), 0);
            if (instr_valid && instr_ready) begin
                check_instr("rnd", pc_m);
                pc_m = pc_m + ilen(pc_m);
                idle = 0;
            end else begin
                idle++;
            end
            if (idle > 60) begin
                check("rnd_stall", 0, 1);
                idle = 0;
            end
            if (jump_en) pc_m = jump_target;
            prev_jump = jump_en;
            tick();
        end
        jump_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage sitting directly upstream of the execute/accumulator datapath and directly downstream of the byte-wide 8K×8 `Memory`. It drives `memRead`/`addressMem`, assembles 1- or 2-byte instructions from `memOut`, and presents each decoded instruction to execute with a valid/ready handshake. Jumps from execute redirect the PC and flush any in-flight fetch.

## Interface
Parameters:
- `RESET_PC`, 13'd0: PC loaded on reset.
- `ADDR_W`, 13: memory address width. Fixed at 13 for this design.

Ports:
- `clock`  in  1: sole clock, rising edge.
- `reset_n`  in  1: asynchronous, active-low reset.
- `fetch_en`  in  1: allows a new fetch to start from IDLE.
- `memRead`  out  1: read strobe to `Memory`.
- `addressMem`  out  13: read address to `Memory`.
- `memOut`  in  8: read data from `Memory`. Valid the cycle after a cycle with `memRead`=1.
- `instr_valid`  out  1: instruction outputs are valid.
- `instr_ready`  in  1: execute accepts the instruction.
- `instr_op`  out  3: byte0[7:5].
- `instr_byte0`  out  8: first instruction byte.
- `instr_addr`  out  13: {byte0[4:0], byte1}. 0 for 1-byte instructions.
- `instr_two_byte`  out  1: instruction was 2 bytes.
- `instr_pc`  out  13: address of byte0.
- `jump_en`  in  1: redirect request, one-cycle pulse.
- `jump_target`  in  13: new PC.
- `pc_wrap`  out  1: sticky wrap flag. Only present under `FETCH_WRAP_CHECK_EN`.

## Operation
- Length decode on byte0[7:5]:
  - 000–011: memory-reference, 2 bytes.
  - 100–111: register/control, 1 byte.
- FSM states: IDLE, B0_REQ, B0_CAP, B1_REQ, B1_CAP, HOLD.
- IDLE:
  - `fetch_en`=1 → B0_REQ.
  - Otherwise stay in IDLE.
- B0_REQ: `memRead`=1, `addressMem`=pc → B0_CAP.
- B0_CAP: capture `memOut` into byte0, then pc ← pc+1.
  - 2-byte opcode → B1_REQ.
  - 1-byte opcode → HOLD.
- B1_REQ: `memRead`=1, `addressMem`=pc → B1_CAP.
- B1_CAP: capture byte1, pc ← pc+1 → HOLD.
- HOLD: `instr_valid`=1; all outputs stable until handshake.
  - On `instr_valid`&&`instr_ready`: go to B0_REQ if `fetch_en`=1, else IDLE.
- `memRead`=0 in every state except B0_REQ and B1_REQ.
- `addressMem` holds its last value when `memRead`=0.
- PC arithmetic is 13-bit modulo; 8191+1 wraps to 0.
- Jump:
  - `jump_en` is sampled in every state and has priority over all other transitions.
  - Effect: pc ← `jump_target`, captured bytes discarded, next state B0_REQ, `instr_valid` low next cycle.
- Jump together with the HOLD handshake: the held instruction counts as consumed and the jump PC wins.
- Jump in IDLE: PC is loaded and the fetch starts regardless of `fetch_en`.
- Reset (asynchronous, including mid-fetch):
  - state=IDLE, pc=`RESET_PC`.
  - `memRead`=0, `addressMem`=0, `instr_valid`=0.
  - All instr_* outputs 0, `pc_wrap`=0.
- The block never writes memory; the write port is owned by execute.

## Timing
- 1-byte instruction: `instr_valid` rises 2 cycles after entering B0_REQ.
- 2-byte instruction: `instr_valid` rises 4 cycles after entering B0_REQ.
- Back-to-back with `instr_ready` held high:
  - 1-byte: one instruction per 3 cycles (HOLD plus 2).
  - 2-byte: one instruction per 5 cycles.
- `instr_ready` may be asserted before `instr_valid`. The transfer occurs on the first cycle both are high.
- Jump flush latency: 1 cycle. The first byte at the target is captured 2 cycles after the jump edge.
- All outputs are registered; there is no combinational path from `instr_ready` or `jump_en` to any output.

## Configuration
- `FETCH_WRAP_CHECK_EN` defined:
  - On a PC increment from 8191 to 0, `pc_wrap` is set and sticky until reset.
  - Fetch continues normally.
- Not defined: the `pc_wrap` port and its logic are absent; wrap is silent.

## Structure
- Shared package `cpu_pkg`:
  - Opcode localparams OP_LDI, OP_ADD, OP_STORE, OP_JMP.
  - ADDR_W = 13.
  - Fetch state enum.
  - Length-decode function `is_two_byte(byte0)`.
- Single module; no sub-module needed. The FSM and the PC register stay together so the jump-priority logic lives in one place.

## Test plan
- Mem[0]=8'hF0, `fetch_en`=1, `instr_ready`=1 → instr_valid at cycle 2 with op=3'b111, two_byte=0, pc=0. `addressMem`=0 observed with `memRead` high.
- Mem[9]=8'h43, mem[10]=8'hE9, start at pc 9 via jump → instr_addr=13'd1001, op=3'b010, two_byte=1, valid 4 cycles after B0_REQ.
- `instr_ready` held low for 5 cycles in HOLD → outputs stable, `memRead`=0 throughout. Next fetch starts at pc+len after `instr_ready` rises.
- `jump_en` with target 13'd43 during B1_CAP of a 2-byte fetch → no valid issued for the flushed instruction; next fetch reads address 43.
- `reset_n` low during B1_REQ → all outputs 0 immediately. After release, with `fetch_en`=1, the fetch restarts at `RESET_PC`.
- With `FETCH_WRAP_CHECK_EN`, 1-byte instruction at 8191 → pc becomes 0 and `pc_wrap`=1, remaining 1. Without the macro, the same fetch proceeds from 0 with no flag.
